// File: rtl/digit_scan_mux.sv
// digit_scan_mux: time-multiplexed scanner for the scoreboard display.
// A free-running prescaler steps a one-hot pointer through CH packed channels;
// each slot loads the selected channel onto a registered output and drives a
// matching one-hot digit enable.
//
// Optional feature macro: SCAN_SNAPSHOT_EN
//   defined   - data_in is captured into a shadow register on entry to
//               channel 0; channels 1..CH-1 read the shadow so one frame
//               shows one coherent value.
//   undefined - every slot reads live data_in at its tick.
//
// Ports:
//   clk          - clock, all state on rising edge
//   rst_n        - asynchronous active-low reset
//   en           - scan enable; low freezes all state
//   data_in      - CH packed W-bit channels, channel k at [k*W +: W]
//   blank_mask   - bit k blanks channel k (sampled at ticks only)
//   sel          - one-hot active-high digit enable, zero when blanked
//   dout         - selected channel data, registered
//   dout_valid   - high from the first tick until reset
//   frame_start  - one-cycle pulse on each entry to channel 0
module digit_scan_mux #(
    parameter int unsigned CH    = 4,
    parameter int unsigned W     = 4,
    parameter int unsigned DIV   = 50000,
    parameter int unsigned DIV_W = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic [CH*W-1:0] data_in,
    input  logic [CH-1:0]   blank_mask,
    output logic [CH-1:0]   sel,
    output logic [W-1:0]    dout,
    output logic            dout_valid,
    output logic            frame_start
);

    localparam int unsigned   BUS_W    = CH * W;
    localparam logic [DIV_W-1:0] PCNT_MAX = DIV_W'(DIV - 1);
    // Reset pointer sits on the last channel so the first tick enters channel 0.
    localparam logic [CH-1:0] PTR_RST  = {1'b1, {(CH-1){1'b0}}};
    localparam logic [CH-1:0] PTR_CH0  = CH'(1);

    logic [DIV_W-1:0] pcnt;
    logic [DIV_W-1:0] pcnt_nxt;
    logic [CH-1:0]    ptr;
    logic [CH-1:0]    ptr_nxt;
    logic             ptr_ok;
    logic             tick;
    logic             enter_ch0;
    logic [CH-1:0]    sel_nxt;
    logic [W-1:0]     dout_nxt;
    logic [BUS_W-1:0] src;

`ifdef SCAN_SNAPSHOT_EN
    logic [BUS_W-1:0] shadow;

    // Frame-coherent copy of the score, refreshed on entry to channel 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow <= '0;
        end else if (enter_ch0) begin
            shadow <= data_in;
        end
    end

    // Channel 0 reads live data, which equals what the shadow captures that edge.
    assign src = {shadow[BUS_W-1:W], data_in[W-1:0]};
`else
    assign src = data_in;
`endif

    // Prescaler, pointer advance with lock-up recovery, and one-hot AND-OR select.
    always_comb begin
        tick      = en && (pcnt == PCNT_MAX);
        pcnt_nxt  = pcnt;
        ptr_nxt   = ptr;
        ptr_ok    = (ptr != '0) && ((ptr & (ptr - CH'(1))) == '0);
        sel_nxt   = '0;
        dout_nxt  = '0;

        if (en) begin
            pcnt_nxt = tick ? '0 : pcnt + DIV_W'(1);
        end

        // A corrupted pointer (zero or multi-hot) is forced back to channel 0.
        if (tick) begin
            ptr_nxt = ptr_ok ? {ptr[CH-2:0], ptr[CH-1]} : PTR_CH0;
        end

        enter_ch0 = tick && ptr_nxt[0];
        sel_nxt   = ptr_nxt & ~blank_mask;

        // Blanked channel has its select bit clear, so it contributes zero.
        for (int k = 0; k < int'(CH); k++) begin
            dout_nxt = dout_nxt | (src[k*W +: W] & {W{sel_nxt[k]}});
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcnt        <= '0;
            ptr         <= PTR_RST;
            sel         <= '0;
            dout        <= '0;
            dout_valid  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            pcnt        <= pcnt_nxt;
            ptr         <= ptr_nxt;
            frame_start <= enter_ch0;
            if (tick) begin
                sel        <= sel_nxt;
                dout       <= dout_nxt;
                dout_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_digit_scan_mux.sv
// Directed bench for digit_scan_mux: CH=4, W=4, DIV=3 main instance plus a
// DIV=1 instance for the per-cycle rotation case.
module tb_digit_scan_mux;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        en_f;
    logic [15:0] data_in;
    logic [15:0] data_f;
    logic [3:0]  blank_mask;
    logic [3:0]  blank_f;
    logic [3:0]  sel;
    logic [3:0]  dout;
    logic        dout_valid;
    logic        frame_start;
    logic [3:0]  sel_f;
    logic [3:0]  dout_f;
    logic        dv_f;
    logic        fs_f;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef SCAN_SNAPSHOT_EN
    localparam bit SNAP = 1'b1;
`else
    localparam bit SNAP = 1'b0;
`endif

    always #5 clk = ~clk;

    digit_scan_mux #(.CH(4), .W(4), .DIV(3), .DIV_W(2)) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .data_in     (data_in),
        .blank_mask  (blank_mask),
        .sel         (sel),
        .dout        (dout),
        .dout_valid  (dout_valid),
        .frame_start (frame_start)
    );

    digit_scan_mux #(.CH(4), .W(4), .DIV(1), .DIV_W(2)) u_fast (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en_f),
        .data_in     (data_f),
        .blank_mask  (blank_f),
        .sel         (sel_f),
        .dout        (dout_f),
        .dout_valid  (dv_f),
        .frame_start (fs_f)
    );

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One DIV=3 slot starting at its tick edge.
    task automatic slot(input string tag, input logic [3:0] s, input logic [3:0] d, input logic fs);
        for (int i = 0; i < 3; i++) begin
            step();
            check({tag, "_sel"}, 16'(sel), 16'(s));
            check({tag, "_dout"}, 16'(dout), 16'(d));
            check({tag, "_fs"}, 16'(frame_start), (i == 0) ? 16'(fs) : 16'(0));
            check({tag, "_valid"}, 16'(dout_valid), 16'(1));
        end
    endtask

    task automatic expect_idle(input string tag);
        check({tag, "_sel"}, 16'(sel), 16'(0));
        check({tag, "_dout"}, 16'(dout), 16'(0));
        check({tag, "_valid"}, 16'(dout_valid), 16'(0));
        check({tag, "_fs"}, 16'(frame_start), 16'(0));
    endtask

    initial begin
        rst_n      = 1'b0;
        en         = 1'b0;
        en_f       = 1'b0;
        data_in    = 16'h4321;
        data_f     = 16'hA5C3;
        blank_mask = 4'b0000;
        blank_f    = 4'b0000;

        // Reset values.
        step();
        step();
        expect_idle("rst");
        check("rst_ptr", 16'(u_dut.ptr), 16'(4'b1000));
        check("rst_pcnt", 16'(u_dut.pcnt), 16'(0));

        @(negedge clk);
        rst_n = 1'b1;
        en    = 1'b1;

        // First tick after 3 enabled cycles.
        step();
        expect_idle("pre1");
        step();
        expect_idle("pre2");

        // Basic rotation over a frame and a bit.
        slot("f0c0", 4'b0001, 4'h1, 1'b1);
        slot("f0c1", 4'b0010, 4'h2, 1'b0);
        slot("f0c2", 4'b0100, 4'h3, 1'b0);
        slot("f0c3", 4'b1000, 4'h4, 1'b0);
        slot("f1c0", 4'b0001, 4'h1, 1'b1);

        // Blank channel 3; mask applied before the ch1 tick.
        blank_mask = 4'b1000;
        slot("bl_c1", 4'b0010, 4'h2, 1'b0);
        slot("bl_c2", 4'b0100, 4'h3, 1'b0);
        slot("bl_c3", 4'b0000, 4'h0, 1'b0);
        blank_mask = 4'b0000;
        slot("bl_c0", 4'b0001, 4'h1, 1'b1);

        // Data change during the channel-1 slot.
        slot("dc_c1", 4'b0010, 4'h2, 1'b0);
        data_in = 16'h8765;
        slot("dc_c2", 4'b0100, SNAP ? 4'h3 : 4'h7, 1'b0);
        slot("dc_c3", 4'b1000, SNAP ? 4'h4 : 4'h8, 1'b0);

        // en low for 5 cycles inside the channel-0 slot; slot spans 8 cycles.
        step();
        check("hold_tick_sel", 16'(sel), 16'(4'b0001));
        check("hold_tick_dout", 16'(dout), 16'(4'h5));
        check("hold_tick_fs", 16'(frame_start), 16'(1));
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check("hold_sel", 16'(sel), 16'(4'b0001));
            check("hold_dout", 16'(dout), 16'(4'h5));
            check("hold_fs", 16'(frame_start), 16'(0));
            check("hold_valid", 16'(dout_valid), 16'(1));
        end
        en = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            check("hold_tail_sel", 16'(sel), 16'(4'b0001));
            check("hold_tail_fs", 16'(frame_start), 16'(0));
        end
        slot("post_c1", 4'b0010, 4'h6, 1'b0);

        // Asynchronous reset mid-slot, between clock edges.
        step();
        check("pre_rst_sel", 16'(sel), 16'(4'b0100));
        check("pre_rst_dout", 16'(dout), 16'(4'h7));
        #2;
        rst_n = 1'b0;
        #1;
        expect_idle("async_rst");
        step();
        expect_idle("rst_hold");
        @(negedge clk);
        rst_n = 1'b1;
        step();
        expect_idle("rel1");
        step();
        expect_idle("rel2");
        slot("rel_c0", 4'b0001, 4'h5, 1'b1);

        // Corrupted pointer recovers to channel 0 at the next tick.
        @(negedge clk);
        force u_dut.ptr = 4'b0110;
        step();
        check("recov_sel", 16'(sel), 16'(4'b0001));
        check("recov_dout", 16'(dout), 16'(4'h5));
        check("recov_fs", 16'(frame_start), 16'(1));
        release u_dut.ptr;

        // DIV=1: channel changes every enabled cycle.
        en_f = 1'b1;
        step();
        check("f_c0_sel", 16'(sel_f), 16'(4'b0001));
        check("f_c0_dout", 16'(dout_f), 16'(4'h3));
        check("f_c0_fs", 16'(fs_f), 16'(1));
        check("f_c0_valid", 16'(dv_f), 16'(1));
        step();
        check("f_c1_sel", 16'(sel_f), 16'(4'b0010));
        check("f_c1_dout", 16'(dout_f), 16'(4'hC));
        check("f_c1_fs", 16'(fs_f), 16'(0));
        step();
        check("f_c2_sel", 16'(sel_f), 16'(4'b0100));
        check("f_c2_dout", 16'(dout_f), 16'(4'h5));
        step();
        check("f_c3_sel", 16'(sel_f), 16'(4'b1000));
        check("f_c3_dout", 16'(dout_f), 16'(4'hA));
        step();
        check("f_w_sel", 16'(sel_f), 16'(4'b0001));
        check("f_w_dout", 16'(dout_f), 16'(4'h3));
        check("f_w_fs", 16'(fs_f), 16'(1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
